led_string_serializer: RTL and testbench



---
 rtl/led_string_pkg.sv | 16 +
 rtl/led_string_serializer.sv | 166 ++++++++++++++++
 tb/tb_led_string_serializer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/led_string_pkg.sv
// Shared types and default 20 MHz timing for the one-wire LED string serializers.
package led_string_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_STALL,
    S_LATCH
  } ser_state_t;

  localparam int unsigned LED_BIT_CYCLES_20M = 24;
  localparam int unsigned LED_T0H_20M        = 6;
  localparam int unsigned LED_T1H_20M        = 12;
  localparam int unsigned LED_LATCH_20M      = 1600;

endpackage

// File: rtl/led_string_serializer.sv
// One-wire NRZ pulse-width serializer for a single SK6812/WS2812 string.
// Pixels arrive over valid/ready, are shifted out MSB first, and each frame
// is closed by a low latch period.
module led_string_serializer
  import led_string_pkg::*;
#(
  parameter int unsigned BITS_PER_PIXEL    = 24,
  parameter int unsigned N_LEDS_PER_STRING = 236,
  parameter int unsigned BIT_CYCLES        = LED_BIT_CYCLES_20M,
  parameter int unsigned T0H_CYCLES        = LED_T0H_20M,
  parameter int unsigned T1H_CYCLES        = LED_T1H_20M,
  parameter int unsigned LATCH_CYCLES      = LED_LATCH_20M
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [BITS_PER_PIXEL-1:0] pixel_data,
  input  logic                      pixel_valid,
  output logic                      pixel_ready,
  output logic                      sdi,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      underrun
);

  localparam int unsigned BW = (BITS_PER_PIXEL > 1)    ? $clog2(BITS_PER_PIXEL)    : 1;
  localparam int unsigned CW = (BIT_CYCLES > 1)        ? $clog2(BIT_CYCLES)        : 1;
  localparam int unsigned PW = (N_LEDS_PER_STRING > 1) ? $clog2(N_LEDS_PER_STRING) : 1;
  localparam int unsigned LW = (LATCH_CYCLES > 1)      ? $clog2(LATCH_CYCLES)      : 1;

  if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES)) begin : g_bad_timing
    $error("led_string_serializer: need 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
  end

  ser_state_t                state_q, state_d;
  logic [BITS_PER_PIXEL-1:0] shreg_q, shreg_d;
  logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]             cyc_cnt_q, cyc_cnt_d;
  logic [PW-1:0]             pix_cnt_q, pix_cnt_d;
  logic [LW-1:0]             lat_cnt_q, lat_cnt_d;
  logic                      sdi_q, sdi_d;
  logic                      busy_q, busy_d;
  logic                      frame_done_q, frame_done_d;
  logic                      underrun_q, underrun_d;
  logic [CW-1:0]             high_cycles;

  logic last_cyc, last_bit, last_pix, pix_end, xfer;

  assign last_cyc = (cyc_cnt_q == CW'(BIT_CYCLES - 1));
  assign last_bit = (bit_cnt_q == BW'(BITS_PER_PIXEL - 1));
  assign last_pix = (pix_cnt_q == PW'(N_LEDS_PER_STRING - 1));
  assign pix_end  = (state_q == S_SHIFT) && last_cyc && last_bit;

  // Ready is combinational so a mid-frame pixel can be taken on the last
  // cycle of the previous one without a gap.
  assign pixel_ready = reset_n &&
                       ((state_q == S_IDLE) || (state_q == S_STALL) || (pix_end && !last_pix));
  assign xfer        = pixel_valid && pixel_ready;

  assign sdi        = sdi_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

  // Next-state logic for the frame FSM, bit timer and pixel/latch counters.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    cyc_cnt_d    = cyc_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    high_cycles  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          state_d   = S_SHIFT;
          shreg_d   = pixel_data;
          bit_cnt_d = '0;
          cyc_cnt_d = '0;
        end
      end
      S_SHIFT: begin
        if (!last_cyc) begin
          cyc_cnt_d = cyc_cnt_q + CW'(1);
        end else begin
          cyc_cnt_d = '0;
          if (!last_bit) begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            shreg_d   = shreg_q << 1;
          end else if (last_pix) begin
            state_d   = S_LATCH;
            lat_cnt_d = '0;
          end else if (xfer) begin
            shreg_d   = pixel_data;
            bit_cnt_d = '0;
            pix_cnt_d = pix_cnt_q + PW'(1);
          end else begin
            state_d    = S_STALL;
            lat_cnt_d  = '0;
            underrun_d = 1'b1;
          end
        end
      end
      S_STALL: begin
        // A pixel arriving on the final stall cycle still resumes the frame.
        if (xfer) begin
          state_d   = S_SHIFT;
          shreg_d   = pixel_data;
          bit_cnt_d = '0;
          cyc_cnt_d = '0;
          pix_cnt_d = pix_cnt_q + PW'(1);
        end else if (lat_cnt_q == LW'(LATCH_CYCLES - 1)) begin
          state_d   = S_IDLE;
          pix_cnt_d = '0;
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end
      S_LATCH: begin
        if (lat_cnt_q == LW'(LATCH_CYCLES - 1)) begin
          state_d      = S_IDLE;
          pix_cnt_d    = '0;
          frame_done_d = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    high_cycles = shreg_d[BITS_PER_PIXEL-1] ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES);
    sdi_d       = (state_d == S_SHIFT) && (cyc_cnt_d < high_cycles);
    busy_d      = (state_d != S_IDLE);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      cyc_cnt_q    <= '0;
      pix_cnt_q    <= '0;
      lat_cnt_q    <= '0;
      sdi_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      cyc_cnt_q    <= cyc_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      sdi_q        <= sdi_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_led_string_serializer.sv
// Self-checking bench for led_string_serializer: a pixel source with per-pixel
// valid delays, and a waveform model built from the frame timing rules.
module tb_led_string_serializer;

  localparam int BPP  = 8;
  localparam int NLED = 3;
  localparam int BC   = 8;
  localparam int T0H  = 2;
  localparam int T1H  = 5;
  localparam int LAT  = 20;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [BPP-1:0] pixel_data = '0;
  logic           pixel_valid = 1'b0;
  logic           pixel_ready, sdi, busy, frame_done, underrun;

  int errors = 0;
  int checks = 0;

  // Source items: pixel word and number of ready cycles valid is withheld.
  logic [BPP-1:0] item_data[$];
  int             item_dly[$];
  // Expected per-cycle outputs {sdi, pixel_ready, busy, frame_done, underrun}.
  logic [4:0]     exp_q[$];

  led_string_serializer #(
    .BITS_PER_PIXEL   (BPP),
    .N_LEDS_PER_STRING(NLED),
    .BIT_CYCLES       (BC),
    .T0H_CYCLES       (T0H),
    .T1H_CYCLES       (T1H),
    .LATCH_CYCLES     (LAT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pixel_data (pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .sdi        (sdi),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input bit s, input bit r, input bit b, input bit f, input bit u);
    exp_q.push_back({s, r, b, f, u});
  endfunction

  function automatic logic [31:0] outs();
    return {27'd0, sdi, pixel_ready, busy, frame_done, underrun};
  endfunction

  // Expected waveform from the frame rules: idle waits, stalls (with abort
  // after LAT cycles), pulse-width bits, and the latch period.
  task automatic build_model();
    int  infr = 0;
    bit  fdp  = 1'b0;
    exp_q.delete();
    for (int i = 0; i < item_data.size(); i++) begin
      int             d  = item_dly[i];
      logic [BPP-1:0] px = item_data[i];
      if (infr != 0) begin
        if (d > LAT) begin
          for (int k = 0; k < LAT; k++) push(1'b0, 1'b1, 1'b1, 1'b0, k == 0);
          infr = 0;
          d    = d - 1 - LAT;
        end else begin
          for (int k = 0; k < d; k++) push(1'b0, 1'b1, 1'b1, 1'b0, k == 0);
        end
      end
      if (infr == 0) begin
        for (int k = 0; k <= d; k++) begin
          push(1'b0, 1'b1, 1'b0, fdp, 1'b0);
          fdp = 1'b0;
        end
      end
      infr++;
      for (int b = BPP - 1; b >= 0; b--) begin
        for (int j = 0; j < BC; j++) begin
          push(j < (px[b] ? T1H : T0H), (b == 0) && (j == BC - 1) && (infr != NLED),
               1'b1, 1'b0, 1'b0);
        end
      end
      if (infr == NLED) begin
        for (int k = 0; k < LAT; k++) push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        fdp  = 1'b1;
        infr = 0;
      end
    end
    if (infr != 0) begin
      for (int k = 0; k < LAT; k++) push(1'b0, 1'b1, 1'b1, 1'b0, k == 0);
    end
    for (int k = 0; k < 3; k++) begin
      push(1'b0, 1'b1, 1'b0, fdp, 1'b0);
      fdp = 1'b0;
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_n     = 1'b0;
    pixel_valid = 1'b0;
    @(negedge clk);
    check_eq(tag, outs(), 32'd0);
    reset_n = 1'b1;
  endtask

  // Drives the item list and compares every cycle; stops at 'cut' (if >= 0)
  // or at the first divergence.
  task automatic run_scenario(input string name, input int cut);
    int idx   = 0;
    int dleft = 0;
    int e0    = errors;
    build_model();
    if (item_dly.size() > 0) dleft = item_dly[0];
    for (int c = 0; c < exp_q.size(); c++) begin
      if (c == cut) break;
      @(negedge clk);
      check_eq($sformatf("%s_c%0d", name, c), outs(), {27'd0, exp_q[c]});
      if (errors != e0) begin
        pixel_valid = 1'b0;
        break;
      end
      if (idx < item_data.size()) begin
        if (pixel_ready && dleft > 0) begin
          dleft--;
          pixel_valid = 1'b0;
          pixel_data  = BPP'($urandom);
        end else begin
          pixel_valid = (dleft == 0);
          pixel_data  = item_data[idx];
        end
        if (pixel_valid && pixel_ready) begin
          idx++;
          if (idx < item_data.size()) dleft = item_dly[idx];
        end
      end else begin
        pixel_valid = 1'b0;
        pixel_data  = BPP'($urandom);
      end
    end
    pixel_valid = 1'b0;
  endtask

  task automatic rand_items(input int n, input int dly_last);
    item_data.delete();
    item_dly.delete();
    for (int i = 0; i < n; i++) begin
      item_data.push_back(BPP'($urandom));
      item_dly.push_back((i == n - 1) ? dly_last : 0);
    end
  endtask

  initial begin
    do_reset("reset_init");

    item_data = '{8'hA5, 8'h00, 8'hFF};
    item_dly  = '{0, 0, 0};
    run_scenario("pattern", -1);

    do_reset("reset_s2");
    rand_items(3, 7);
    run_scenario("short_stall", -1);

    do_reset("reset_s3");
    rand_items(5, 0);
    item_dly[2] = LAT + 1;
    run_scenario("long_stall", -1);

    do_reset("reset_s4");
    rand_items(3, 0);
    run_scenario("pre_reset", 93);
    do_reset("reset_mid");
    rand_items(3, 0);
    run_scenario("post_reset", -1);

    do_reset("reset_s5");
    rand_items(6, 0);
    run_scenario("b2b", -1);

    for (int r = 0; r < 12; r++) begin
      int n = $urandom_range(1, 8);
      do_reset($sformatf("reset_r%0d", r));
      item_data.delete();
      item_dly.delete();
      for (int i = 0; i < n; i++) begin
        item_data.push_back(BPP'($urandom));
        item_dly.push_back(($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, LAT + 4));
      end
      run_scenario($sformatf("rand%0d", r), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
